// File: rtl/bus_regfile.sv
// Bank of WIDTH-bit registers sharing one tri-state bus, with a built-in
// src->dst move sequencer and a sticky multi-driver contention flag.
module bus_regfile #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDXW     = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  inout  wire  [WIDTH-1:0]          bus,
  input  logic [NUM_REGS-1:0]       ext_load,
  input  logic [NUM_REGS-1:0]       ext_out,
  input  logic [NUM_REGS-1:0]       reg_clr,
  input  logic                      mv_req,
  input  logic [IDXW-1:0]           mv_src,
  input  logic [IDXW-1:0]           mv_dst,
  output logic                      mv_busy,
  output logic                      mv_done,
  output logic                      mv_err,
  output logic                      contention,
  output logic [NUM_REGS*WIDTH-1:0] q
);

  typedef enum logic [1:0] {StIdle, StSettle, StLatch, StDone} state_e;

  // One extra bit so NUM_REGS itself is representable when it equals 2**IDXW.
  localparam logic [IDXW:0] NumRegsW = (IDXW + 1)'(NUM_REGS);

  state_e           state_q;
  logic [IDXW-1:0]  src_q, dst_q;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             busy_q, done_q, err_q, cont_q;

  logic [IDXW-1:0]  out_idx;
  logic             out_onehot, out_multi, idx_valid;
  logic             drive_en;
  logic [WIDTH-1:0] drive_val;

  assign out_onehot = $onehot(ext_out);
  assign out_multi  = !$onehot0(ext_out);
  assign idx_valid  = ({1'b0, mv_src} < NumRegsW) && ({1'b0, mv_dst} < NumRegsW);

  always_comb begin
    out_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ext_out[i]) out_idx = IDXW'(i);
    end
  end

  always_comb begin
    drive_en  = 1'b0;
    drive_val = regs_q[src_q];
    case (state_q)
      StIdle: begin
        drive_en  = out_onehot;
        drive_val = regs_q[out_idx];
      end
      StSettle, StLatch: drive_en = 1'b1;
      default:           drive_en = 1'b0;
    endcase
  end

  assign bus = drive_en ? drive_val : 'z;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == StIdle && out_multi) cont_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (mv_req) begin
            src_q <= mv_src;
            dst_q <= mv_dst;
            if (idx_valid) begin
              state_q <= StSettle;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        StSettle: state_q <= StLatch;
        StLatch: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_clr[i]) begin
          regs_q[i] <= '0;
        end else if (state_q == StLatch && dst_q == IDXW'(i)) begin
          regs_q[i] <= bus;
        end else if (state_q == StIdle && ext_load[i]) begin
          regs_q[i] <= bus;
        end
      end
    end
  end

  always_comb begin
    q = '0;
    for (int i = 0; i < NUM_REGS; i++) q[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign mv_busy    = busy_q;
  assign mv_done    = done_q;
  assign mv_err     = err_q;
  assign contention = cont_q;

endmodule

// File: tb/tb_bus_regfile.sv
// Self-checking bench for bus_regfile: a 4-register instance for the main features
// and a 3-register instance for out-of-range move indices.
module tb_bus_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  wire  [7:0]  bus;
  logic        tb_en;
  logic [7:0]  tb_val;
  logic [3:0]  ext_load, ext_out, reg_clr;
  logic        mv_req;
  logic [1:0]  mv_src, mv_dst;
  logic        mv_busy, mv_done, mv_err, contention;
  logic [31:0] q;

  assign bus = tb_en ? tb_val : 'z;

  wire  [7:0]  bus3;
  logic        tb3_en;
  logic [7:0]  tb3_val;
  logic [2:0]  ext_load3;
  logic        mv_req3;
  logic [1:0]  mv_src3, mv_dst3;
  logic        busy3, done3, err3, cont3;
  logic [23:0] q3;

  assign bus3 = tb3_en ? tb3_val : 'z;

  bus_regfile #(.WIDTH(8), .NUM_REGS(4), .IDXW(2)) u_dut (
    .clk(clk), .clr(clr), .bus(bus), .ext_load(ext_load), .ext_out(ext_out),
    .reg_clr(reg_clr), .mv_req(mv_req), .mv_src(mv_src), .mv_dst(mv_dst),
    .mv_busy(mv_busy), .mv_done(mv_done), .mv_err(mv_err), .contention(contention), .q(q)
  );

  bus_regfile #(.WIDTH(8), .NUM_REGS(3), .IDXW(2)) u_dut3 (
    .clk(clk), .clr(clr), .bus(bus3), .ext_load(ext_load3), .ext_out(3'b000),
    .reg_clr(3'b000), .mv_req(mv_req3), .mv_src(mv_src3), .mv_dst(mv_dst3),
    .mv_busy(busy3), .mv_done(done3), .mv_err(err3), .contention(cont3), .q(q3)
  );

  typedef struct {
    logic [1:0] dst;
    logic [7:0] val;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl[4];
  int         checks = 0;
  int         errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mdl_q();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  // Undriven bus reads as Z in four-state simulators and 0 in two-state ones.
  function automatic logic released(input logic [7:0] b);
    return (b === 8'hzz) || (b === 8'h00);
  endfunction

  task automatic test_reset();
    clr = 1'b1;
    tb_en = 1'b0; tb_val = '0; ext_load = '0; ext_out = '0; reg_clr = '0;
    mv_req = 1'b0; mv_src = '0; mv_dst = '0;
    tb3_en = 1'b0; tb3_val = '0; ext_load3 = '0; mv_req3 = 1'b0; mv_src3 = '0; mv_dst3 = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    tick();
    tick();
    clr = 1'b0;
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++;
    if ({mv_busy, mv_done, mv_err, contention} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {mv_busy, mv_done, mv_err, contention});
    end
    checks++;
    if (q3 !== 24'h0) begin errors++; $display("FAIL reset_q3 got=%h exp=0", q3); end
  endtask

  task automatic test_load_drive();
    logic [7:0] vals[4];
    vals = '{8'h3C, 8'hA5, 8'h69, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      tb_en = 1'b1; tb_val = vals[i]; ext_load = 4'(1 << i);
      tick();
      ext_load = '0; tb_en = 1'b0;
      mdl[i] = vals[i];
      checks++;
      if (q !== mdl_q()) begin errors++; $display("FAIL load%0d got=%h exp=%h", i, q, mdl_q()); end
    end
    for (int i = 0; i < 4; i++) begin
      ext_out = 4'(1 << i);
      #1;
      checks++;
      if (bus !== mdl[i]) begin errors++; $display("FAIL drive%0d got=%h exp=%h", i, bus, mdl[i]); end
    end
    ext_out = '0;
    #1;
    checks++;
    if (!released(bus)) begin errors++; $display("FAIL idle_release got=%h exp=Z", bus); end
  endtask

  task automatic test_move();
    exp_t e;
    mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd2;
    sb.push_back('{dst: 2'd2, val: mdl[0], err: 1'b0});
    tick();
    mv_req = 1'b0;
    checks++;
    if ({mv_busy, mv_done} !== 2'b10) begin
      errors++; $display("FAIL move_settle got=%b exp=10", {mv_busy, mv_done});
    end
    checks++;
    if (bus !== mdl[0]) begin errors++; $display("FAIL move_bus got=%h exp=%h", bus, mdl[0]); end
    tick();
    checks++;
    if ({mv_busy, mv_done} !== 2'b10) begin
      errors++; $display("FAIL move_latch got=%b exp=10", {mv_busy, mv_done});
    end
    tick();
    checks++;
    if ({mv_busy, mv_done, mv_err} !== 3'b010) begin
      errors++; $display("FAIL move_done got=%b exp=010", {mv_busy, mv_done, mv_err});
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL move_sb got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      mdl[e.dst] = e.val;
      if (q[int'(e.dst)*8 +: 8] !== e.val || mv_err !== e.err) begin
        errors++; $display("FAIL move_dst got=%h exp=%h", q[int'(e.dst)*8 +: 8], e.val);
      end
    end
    checks++;
    if (!released(bus)) begin errors++; $display("FAIL done_release got=%h exp=Z", bus); end
    tick();
    checks++;
    if (mv_done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", mv_done); end
    checks++;
    if (q !== mdl_q()) begin errors++; $display("FAIL move_q got=%h exp=%h", q, mdl_q()); end
  endtask

  task automatic test_same_reg();
    exp_t e;
    mv_req = 1'b1; mv_src = 2'd1; mv_dst = 2'd1;
    sb.push_back('{dst: 2'd1, val: mdl[1], err: 1'b0});
    tick();
    mv_req = 1'b0;
    tick();
    tick();
    checks++;
    if (sb.size() == 0 || mv_done !== 1'b1) begin
      errors++; $display("FAIL same_done got=%b exp=1", mv_done);
    end else begin
      e = sb.pop_front();
      if (q[int'(e.dst)*8 +: 8] !== e.val || mv_err !== e.err) begin
        errors++; $display("FAIL same_dst got=%h exp=%h", q[int'(e.dst)*8 +: 8], e.val);
      end
    end
    tick();
  endtask

  task automatic test_clr_dst_latch();
    exp_t e;
    mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd3;
    sb.push_back('{dst: 2'd3, val: 8'h00, err: 1'b0});
    tick();
    mv_req = 1'b0;
    tick();
    reg_clr = 4'b1000;
    tick();
    reg_clr = '0;
    checks++;
    if (sb.size() == 0 || mv_done !== 1'b1) begin
      errors++; $display("FAIL clrdst_done got=%b exp=1", mv_done);
    end else begin
      e = sb.pop_front();
      mdl[e.dst] = e.val;
      if (q !== mdl_q()) begin errors++; $display("FAIL clrdst_q got=%h exp=%h", q, mdl_q()); end
    end
    tick();
  endtask

  task automatic test_ext_load_settle();
    exp_t e;
    mv_req = 1'b1; mv_src = 2'd1; mv_dst = 2'd0;
    sb.push_back('{dst: 2'd0, val: mdl[1], err: 1'b0});
    tick();
    mv_req = 1'b0;
    ext_load = 4'b0100;
    tick();
    tick();
    ext_load = '0;
    checks++;
    if (sb.size() == 0 || mv_done !== 1'b1) begin
      errors++; $display("FAIL extld_done got=%b exp=1", mv_done);
    end else begin
      e = sb.pop_front();
      mdl[e.dst] = e.val;
      if (q !== mdl_q()) begin errors++; $display("FAIL extld_q got=%h exp=%h", q, mdl_q()); end
    end
    tick();
  endtask

  task automatic test_clr_src_settle();
    exp_t e;
    mv_req = 1'b1; mv_src = 2'd2; mv_dst = 2'd1;
    sb.push_back('{dst: 2'd1, val: 8'h00, err: 1'b0});
    mdl[2] = 8'h00;
    tick();
    mv_req = 1'b0;
    reg_clr = 4'b0100;
    tick();
    reg_clr = '0;
    tick();
    checks++;
    if (sb.size() == 0 || mv_done !== 1'b1) begin
      errors++; $display("FAIL clrsrc_done got=%b exp=1", mv_done);
    end else begin
      e = sb.pop_front();
      mdl[e.dst] = e.val;
      if (q !== mdl_q()) begin errors++; $display("FAIL clrsrc_q got=%h exp=%h", q, mdl_q()); end
    end
    tick();
  endtask

  task automatic test_invalid();
    logic [7:0] vals[3];
    vals = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      tb3_en = 1'b1; tb3_val = vals[i]; ext_load3 = 3'(1 << i);
      tick();
    end
    tb3_en = 1'b0; ext_load3 = '0;
    checks++;
    if (q3 !== 24'h332211) begin errors++; $display("FAIL inv_load got=%h exp=332211", q3); end
    mv_req3 = 1'b1; mv_src3 = 2'd3; mv_dst3 = 2'd0;
    tick();
    mv_src3 = 2'd0; mv_dst3 = 2'd1;  // valid request held through DONE must be ignored
    checks++;
    if ({busy3, done3, err3} !== 3'b011) begin
      errors++; $display("FAIL inv_src got=%b exp=011", {busy3, done3, err3});
    end
    checks++;
    if (!released(bus3) || q3 !== 24'h332211) begin
      errors++; $display("FAIL inv_nochange bus=%h q=%h exp=Z,332211", bus3, q3);
    end
    tick();
    mv_req3 = 1'b0;
    checks++;
    if ({busy3, done3, err3} !== 3'b000) begin
      errors++; $display("FAIL inv_ignore got=%b exp=000", {busy3, done3, err3});
    end
    mv_req3 = 1'b1; mv_src3 = 2'd0; mv_dst3 = 2'd3;
    tick();
    mv_req3 = 1'b0;
    checks++;
    if ({busy3, done3, err3} !== 3'b011 || q3 !== 24'h332211) begin
      errors++; $display("FAIL inv_dst got=%b q=%h exp=011,332211", {busy3, done3, err3}, q3);
    end
    tick();
  endtask

  task automatic test_contention();
    tb_en = 1'b1; tb_val = 8'h5A; ext_load = 4'b0010;
    tick();
    tb_en = 1'b0; ext_load = '0;
    mdl[1] = 8'h5A;
    checks++;
    if (contention !== 1'b0) begin errors++; $display("FAIL cont_pre got=%b exp=0", contention); end
    ext_out = 4'b0011;
    #1;
    checks++;
    if (!released(bus)) begin errors++; $display("FAIL cont_bus got=%h exp=Z", bus); end
    tick();
    ext_out = '0;
    checks++;
    if (contention !== 1'b1) begin errors++; $display("FAIL cont_set got=%b exp=1", contention); end
    tick();
    tick();
    checks++;
    if (contention !== 1'b1) begin errors++; $display("FAIL cont_hold got=%b exp=1", contention); end
  endtask

  task automatic test_clr_mid_move();
    int dones;
    mv_req = 1'b1; mv_src = 2'd0; mv_dst = 2'd2;
    tick();
    mv_req = 1'b0;
    clr = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    checks++;
    if (q !== 32'h0 || !released(bus)) begin
      errors++; $display("FAIL clr_async q=%h bus=%h exp=0,Z", q, bus);
    end
    checks++;
    if ({mv_busy, mv_done, contention} !== 3'b000) begin
      errors++; $display("FAIL clr_flags got=%b exp=000", {mv_busy, mv_done, contention});
    end
    tick();
    clr = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mv_done === 1'b1 || mv_busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL clr_nodone got=%0d exp=0", dones); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_load_drive();
    test_move();
    test_same_reg();
    test_clr_dst_latch();
    test_ext_load_settle();
    test_clr_src_settle();
    test_invalid();
    test_contention();
    test_clr_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
